usb_packet_reader: RTL and testbench
====================================

# usb_packet_reader

Receive-side USB line decoder that recovers one fixed-format packet from the raw differential pair. It oversamples the line, detects SYNC, removes NRZI encoding and bit stuffing, and splits the payload into PID, 64-bit data and 16-bit CRC fields. It signals end-of-packet and presents the fields to downstream packet logic. It sits directly behind the USB pad/transceiver in the receive path.

## Interface
- CLKS_PER_BIT, default 30 — system clocks per USB bit time (300 MHz clock / 10 Mb/s line); must be ≥ 8.
- clk  in  1  system clock, 300 MHz nominal; all logic is on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- USBdata  in  2  raw line {D+, D-}: 2'b10 = J (idle), 2'b01 = K, 2'b00 = SE0, 2'b11 = illegal, treated as J.
- PID_data  out  8  PID byte of the last completed packet.
- data  out  64  data payload of the last completed packet.
- CRC_data  out  16  CRC field of the last completed packet, as received and not checked.
- EOP_found  out  1  high once a packet has ended with EOP; held.

## Operation
- Input path: USBdata passes through a 2-flop synchronizer before any use.
- Bit recovery:
  - A phase counter restarts on every synchronized line-state change.
  - The line is sampled when the counter reaches CLKS_PER_BIT/2, then every CLKS_PER_BIT after that while there is no change.
- NRZI decoding: a J/K sample equal to the previous J/K sample is bit 1; a differing sample is bit 0.
- State machine: IDLE → SYNC → PID → DATA → CRC → EOP → IDLE.
  - IDLE: the line is J. The first K sample enters SYNC.
  - SYNC: expects the raw sequence K J K J K J K K. Any mismatch returns to IDLE. The final K is the NRZI reference for the first PID bit.
  - PID: 8 bits. DATA: 64 bits. CRC: 16 bits.
  - Each field is received LSB first: the first bit lands in field[0].
  - Extra J/K bits after the CRC field are ignored.
  - EOP detection: two consecutive SE0 samples followed by a J sample. This is valid from the PID, DATA, CRC or post-CRC phase.
  - SE0 in IDLE or SYNC returns to IDLE.
- Bit unstuffing:
  - A counter tracks consecutive decoded 1s, counting from the first PID bit.
  - After six 1s, the next decoded bit is discarded and is not counted toward the field lengths. The counter then clears.
  - Any decoded 0 clears the counter.
- Field capture:
  - Bits shift into internal registers.
  - PID_data, data and CRC_data load from those registers only on the clock an EOP completes.
  - If EOP arrives early (short packet), fields not yet received load as zero.
- EOP_found:
  - Set on the same edge the fields load.
  - Cleared when a new SYNC begins, or by rst.
  - Fields hold their values until the next EOP.
- Reset mid-packet: everything returns to IDLE with reset values. The partial packet is discarded.

## Timing
- Reset values: PID_data = 8'h00, data = 64'h0, CRC_data = 16'h0, EOP_found = 0, state = IDLE.
- Sampling latency: 2 clocks (synchronizer) plus CLKS_PER_BIT/2 clocks after a line edge.
- Output latency: fields and EOP_found update one clock after the J sample that completes EOP. That is about CLKS_PER_BIT/2 + 3 clocks after the final J begins on the line.
- No handshake: outputs are level data, valid while EOP_found = 1.
- Jitter tolerance: resynchronizing on every edge tolerates ±CLKS_PER_BIT/4 clocks of edge jitter per bit.

## Configuration
- USB_READER_STUFF_ERR_EN:
  - When defined, a decoded 1 where a stuffed 0 is required is a bit-stuff violation (seven consecutive 1s). The packet is aborted: return to IDLE, outputs and EOP_found unchanged.
  - When undefined, the stuffed-bit position is discarded whatever its value, and no error is detected.

## Test plan
- Reset: assert rst mid-line → all outputs 0, EOP_found 0. Release; line idle J for 1 µs → outputs unchanged.
- Nominal packet with one stuffed bit: idle J, SYNC KJKJKJKK, then PID 0xC3, data 0x00FF77BB33DD5599 and CRC 0xE237, NRZI-encoded with a stuffed 0 after the six-1 run, then SE0 SE0 J (100 ns bit time).
  - Required: PID_data = 0xC3, data = 0x00FF77BB33DD5599, CRC_data = 0xE237, EOP_found = 1 within 20 clocks of the final J.
- Corrupted SYNC: send KJKJJ → state returns to IDLE; no field update.
- Short packet: SYNC, PID 0xA5, 8 data bits 0x3C, then EOP → PID_data = 0xA5, data = 0x3C, CRC_data = 0, EOP_found = 1.
- Back-to-back packets: a second packet (PID 0x4B) after EOP → EOP_found drops at the second SYNC and rises at the second EOP with PID_data = 0x4B.
- With USB_READER_STUFF_ERR_EN defined: seven consecutive 1s in DATA → no EOP_found, previous outputs retained.

Source files
------------

// File: rtl/usb_packet_reader.sv
// USB receive-side packet decoder: oversampled bit recovery, SYNC detection, NRZI decoding,
// bit unstuffing and PID/DATA/CRC field capture. Define USB_READER_STUFF_ERR_EN to abort on stuff violations.
module usb_packet_reader #(
    parameter int CLKS_PER_BIT = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  USBdata,
    output logic [7:0]  PID_data,
    output logic [63:0] data,
    output logic [15:0] CRC_data,
    output logic        EOP_found
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {LS_J, LS_K, LS_SE0} line_t;
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_POST, S_EOP} state_t;

    logic [1:0]    sync1_q, sync2_q;
    line_t         line_d, line_prev_q;
    logic [CW-1:0] phase_q;
    logic          sample_d;

    state_t        state_q;
    logic [2:0]    sync_idx_q;
    line_t         last_jk_q;
    logic [2:0]    ones_q;
    logic [6:0]    bitcnt_q;
    logic          se0_two_q;
    logic [7:0]    pid_q;
    logic [63:0]   data_q;
    logic [15:0]   crc_q;

    logic          bit_d, stuffed_d, stuff_err_d, sync_expect_k_d;

    always_comb begin
        case (sync2_q)
            2'b01:   line_d = LS_K;
            2'b00:   line_d = LS_SE0;
            default: line_d = LS_J;
        endcase
    end

    assign sample_d        = (line_d == line_prev_q) && (phase_q == '0);
    assign bit_d           = (line_d == last_jk_q);
    assign stuffed_d       = (ones_q == 3'd6);
    // SYNC is K J K J K J K K: K on every even position and on the last one
    assign sync_expect_k_d = !sync_idx_q[0] || (sync_idx_q == 3'd7);

`ifdef USB_READER_STUFF_ERR_EN
    assign stuff_err_d = stuffed_d && bit_d && (state_q != S_POST);
`else
    assign stuff_err_d = 1'b0;
`endif

    // Two-flop synchronizer and edge-resynchronized phase counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 2'b10;
            sync2_q     <= 2'b10;
            line_prev_q <= LS_J;
            phase_q     <= CW'(HALF - 1);
        end else begin
            sync1_q     <= USBdata;
            sync2_q     <= sync1_q;
            line_prev_q <= line_d;
            if (line_d != line_prev_q)
                phase_q <= CW'(HALF - 1);
            else if (phase_q == '0)
                phase_q <= CW'(CLKS_PER_BIT - 1);
            else
                phase_q <= phase_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync_idx_q <= 3'd0;
            last_jk_q  <= LS_J;
            ones_q     <= 3'd0;
            bitcnt_q   <= 7'd0;
            se0_two_q  <= 1'b0;
            pid_q      <= 8'h00;
            data_q     <= 64'h0;
            crc_q      <= 16'h0;
            PID_data   <= 8'h00;
            data       <= 64'h0;
            CRC_data   <= 16'h0;
            EOP_found  <= 1'b0;
        end else if (sample_d) begin
            case (state_q)
                S_IDLE: begin
                    if (line_d == LS_K) begin
                        state_q    <= S_SYNC;
                        sync_idx_q <= 3'd1;
                        EOP_found  <= 1'b0;
                    end
                end
                S_SYNC: begin
                    if (line_d == LS_SE0 || ((line_d == LS_K) != sync_expect_k_d)) begin
                        state_q <= S_IDLE;
                    end else if (sync_idx_q == 3'd7) begin
                        state_q   <= S_PID;
                        last_jk_q <= LS_K;
                        ones_q    <= 3'd0;
                        bitcnt_q  <= 7'd0;
                        pid_q     <= 8'h00;
                        data_q    <= 64'h0;
                        crc_q     <= 16'h0;
                    end else begin
                        sync_idx_q <= sync_idx_q + 3'd1;
                    end
                end
                S_PID, S_DATA, S_CRC, S_POST: begin
                    if (line_d == LS_SE0) begin
                        state_q   <= S_EOP;
                        se0_two_q <= 1'b0;
                    end else begin
                        last_jk_q <= line_d;
                        if (stuff_err_d) begin
                            state_q <= S_IDLE;
                        end else if (stuffed_d) begin
                            ones_q <= 3'd0;
                        end else begin
                            ones_q <= bit_d ? ones_q + 3'd1 : 3'd0;
                            case (state_q)
                                S_PID: begin
                                    pid_q[bitcnt_q[2:0]] <= bit_d;
                                    if (bitcnt_q == 7'd7) begin
                                        state_q  <= S_DATA;
                                        bitcnt_q <= 7'd0;
                                    end else begin
                                        bitcnt_q <= bitcnt_q + 7'd1;
                                    end
                                end
                                S_DATA: begin
                                    data_q[bitcnt_q[5:0]] <= bit_d;
                                    if (bitcnt_q == 7'd63) begin
                                        state_q  <= S_CRC;
                                        bitcnt_q <= 7'd0;
                                    end else begin
                                        bitcnt_q <= bitcnt_q + 7'd1;
                                    end
                                end
                                S_CRC: begin
                                    crc_q[bitcnt_q[3:0]] <= bit_d;
                                    if (bitcnt_q == 7'd15) begin
                                        state_q  <= S_POST;
                                        bitcnt_q <= 7'd0;
                                    end else begin
                                        bitcnt_q <= bitcnt_q + 7'd1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_EOP: begin
                    if (line_d == LS_SE0) begin
                        se0_two_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        if (line_d == LS_J && se0_two_q) begin
                            PID_data  <= pid_q;
                            data      <= data_q;
                            CRC_data  <= crc_q;
                            EOP_found <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_packet_reader.sv
// Directed bench for usb_packet_reader: table of packets encoded on the line, plus reset,
// corrupted-SYNC and (with USB_READER_STUFF_ERR_EN) stuff-violation sequences.
`timescale 1ns/1ps
module tb_usb_packet_reader;
    localparam int CPB = 30;
    localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  USBdata;
    logic [7:0]  PID_data;
    logic [63:0] data;
    logic [15:0] CRC_data;
    logic        EOP_found;

    int n_checks = 0;
    int n_fail   = 0;

    usb_packet_reader #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .USBdata(USBdata),
        .PID_data(PID_data), .data(data), .CRC_data(CRC_data), .EOP_found(EOP_found)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pid;
        logic [63:0] d;
        int          nd;
        logic [15:0] crc;
        int          nc;
        logic [7:0]  e_pid;
        logic [63:0] e_d;
        logic [15:0] e_crc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sym(input logic [1:0] s, input int nbits);
        USBdata = s;
        repeat (nbits * CPB) @(posedge clk);
        #1;
    endtask

    // Idle, SYNC, then the fields LSB first, optionally bit-stuffed, NRZI-encoded from the final SYNC K
    task automatic send_body(input logic [7:0] pid, input logic [63:0] d, input int nd,
                             input logic [15:0] crc, input int nc, input bit stuff);
        bit bits[$];
        bit raw[$];
        int ones;
        logic [1:0] lvl;
        for (int i = 0; i < 8; i++)  bits.push_back(pid[i]);
        for (int i = 0; i < nd; i++) bits.push_back(d[i]);
        for (int i = 0; i < nc; i++) bits.push_back(crc[i]);
        ones = 0;
        foreach (bits[i]) begin
            raw.push_back(bits[i]);
            ones = bits[i] ? ones + 1 : 0;
            if (stuff && ones == 6) begin
                raw.push_back(1'b0);
                ones = 0;
            end
        end
        sym(LJ, 3);
        sym(LK, 1); sym(LJ, 1); sym(LK, 1); sym(LJ, 1);
        sym(LK, 1); sym(LJ, 1); sym(LK, 2);
        lvl = LK;
        foreach (raw[i]) begin
            if (!raw[i]) lvl = (lvl == LK) ? LJ : LK;
            sym(lvl, 1);
        end
    endtask

    task automatic send_eop(output bit seen);
        sym(LSE0, 2);
        USBdata = LJ;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = EOP_found;
        end
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx);
        bit seen;
        send_body(vecs[idx].pid, vecs[idx].d, vecs[idx].nd, vecs[idx].crc, vecs[idx].nc, 1'b1);
        check($sformatf("v%0d_eop_cleared_by_sync", idx), EOP_found, 1'b0);
        send_eop(seen);
        check($sformatf("v%0d_eop_within_20", idx), seen, 1'b1);
        check($sformatf("v%0d_eop_held", idx), EOP_found, 1'b1);
        check($sformatf("v%0d_pid", idx), PID_data, vecs[idx].e_pid);
        check($sformatf("v%0d_data", idx), data, vecs[idx].e_d);
        check($sformatf("v%0d_crc", idx), CRC_data, vecs[idx].e_crc);
        $display("packet %0d: PID=%h data=%h CRC=%h EOP=%0b", idx, PID_data, data, CRC_data, EOP_found);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pid"}, PID_data, 8'h00);
        check({tag, "_data"}, data, 64'h0);
        check({tag, "_crc"}, CRC_data, 16'h0);
        check({tag, "_eop"}, EOP_found, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'hC3, 64'h00FF77BB33DD5599, 64, 16'hE237, 16, 8'hC3, 64'h00FF77BB33DD5599, 16'hE237};
        vecs[1] = '{8'hA5, 64'h000000000000003C, 8,  16'h0000, 0,  8'hA5, 64'h000000000000003C, 16'h0000};
        vecs[2] = '{8'h4B, 64'h0123456789ABCDEF, 64, 16'h1234, 16, 8'h4B, 64'h0123456789ABCDEF, 16'h1234};
        vecs[3] = '{8'h69, 64'hFFFFFFFFFFFFFFFF, 64, 16'hFFFF, 16, 8'h69, 64'hFFFFFFFFFFFFFFFF, 16'hFFFF};
        vecs[4] = '{8'hE1, 64'h0000000000000000, 0,  16'h0000, 0,  8'hE1, 64'h0000000000000000, 16'h0000};
        vecs[5] = '{8'h2D, 64'h8000000000000001, 64, 16'h00A5, 8,  8'h2D, 64'h8000000000000001, 16'h00A5};

        rst = 1'b1;
        USBdata = LK;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        USBdata = LJ;
        repeat (100) @(posedge clk);
        #1;
        check_zero("idle_after_reset");
        $display("reset: PID=%h data=%h CRC=%h EOP=%0b", PID_data, data, CRC_data, EOP_found);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Corrupted SYNC followed by an EOP-like pattern must leave the fields alone
        sym(LJ, 3);
        sym(LK, 1); sym(LJ, 1); sym(LK, 1); sym(LJ, 3);
        sym(LSE0, 2); sym(LJ, 3);
        check("badsync_pid", PID_data, vecs[5].e_pid);
        check("badsync_data", data, vecs[5].e_d);
        check("badsync_crc", CRC_data, vecs[5].e_crc);
        $display("corrupted sync: PID=%h data=%h CRC=%h EOP=%0b", PID_data, data, CRC_data, EOP_found);

        // Reset in the middle of a packet, then recovery on the next good packet
        send_body(8'h5A, 64'h00000000000000F0, 16, 16'h0000, 0, 1'b1);
        sym(LK, 1); sym(LJ, 1);
        rst = 1'b1;
        #1;
        check_zero("midpkt_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        USBdata = LJ;
        repeat (100) @(posedge clk);
        #1;
        check_zero("midpkt_idle");
        $display("mid-packet reset: PID=%h data=%h CRC=%h EOP=%0b", PID_data, data, CRC_data, EOP_found);
        run_vec(0);

`ifdef USB_READER_STUFF_ERR_EN
        begin
            bit seen;
            send_body(8'h00, 64'hFFFFFFFFFFFFFFFF, 64, 16'h0000, 0, 1'b0);
            send_eop(seen);
            check("stufferr_no_eop", seen, 1'b0);
            check("stufferr_pid", PID_data, vecs[0].e_pid);
            check("stufferr_data", data, vecs[0].e_d);
            check("stufferr_crc", CRC_data, vecs[0].e_crc);
            $display("stuff violation: PID=%h data=%h CRC=%h EOP=%0b", PID_data, data, CRC_data, EOP_found);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
